// File: rtl/pipelined_perf_monitor.sv
// Commit-stage performance monitor: saturating event counters with atomic
// snapshot, start/stop/freeze control and a mispredicted-branch PC trace FIFO.
module pipelined_perf_monitor #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned N_EXT       = 2,
   parameter int unsigned TRACE_DEPTH = 8,
   parameter int unsigned MISS_LIMIT  = 0
) (
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic                            i_start,
   input  logic                            i_stop,
   input  logic                            i_clear,
   input  logic                            i_snap,
   input  logic                            i_insn_vld,
   input  logic                            i_ctrl,
   input  logic                            i_mispred,
   input  logic [31:0]                     i_pc,
   input  logic [((N_EXT > 0) ? N_EXT : 1)-1:0] i_ext_evt,
   input  logic [3:0]                      i_rd_sel,
   output logic [CNT_W-1:0]                o_rd_data,
   output logic [1:0]                      o_state,
   output logic [31:0]                     o_trace_pc,
   output logic                            o_trace_vld,
   input  logic                            i_trace_pop,
   output logic [$clog2(TRACE_DEPTH):0]    o_trace_cnt,
   output logic                            o_trace_ovf
);

   localparam int unsigned NCNT = 4 + N_EXT;
   localparam int unsigned AW   = $clog2(TRACE_DEPTH);

   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_RUNNING = 2'd1,
      ST_FROZEN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [NCNT-1:0]  inc;
   logic [CNT_W-1:0] cnt_q    [NCNT];
   logic [CNT_W-1:0] cnt_nxt  [NCNT];
   logic [CNT_W-1:0] shadow_q [NCNT];
   logic [CNT_W-1:0] rd_mux;
   logic             freeze_hit;

   always_comb begin
      inc    = '0;
      inc[0] = (state_q == ST_RUNNING);
      inc[1] = inc[0] & i_insn_vld;
      inc[2] = inc[1] & i_ctrl;
      inc[3] = inc[2] & i_mispred;
      for (int unsigned k = 0; k < N_EXT; k++) begin
         inc[4+k] = inc[0] & i_ext_evt[k];
      end
      for (int unsigned i = 0; i < NCNT; i++) begin
         cnt_nxt[i] = (inc[i] && (cnt_q[i] != '1)) ? cnt_q[i] + 1'b1 : cnt_q[i];
      end
   end

   assign freeze_hit = (MISS_LIMIT != 0) && (cnt_nxt[3] == CNT_W'(MISS_LIMIT));

   always_comb begin
      state_d = state_q;
      if (i_clear) begin
         state_d = ST_STOPPED;
      end else begin
         case (state_q)
            ST_STOPPED: if (i_start) state_d = ST_RUNNING;
            ST_RUNNING: begin
               if (i_stop)          state_d = ST_STOPPED;
               else if (freeze_hit) state_d = ST_FROZEN;
            end
            ST_FROZEN:  if (i_stop) state_d = ST_STOPPED;
            default:    state_d = ST_STOPPED;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) state_q <= ST_STOPPED;
      else         state_q <= state_d;
   end

   assign o_state = state_q;

   // Snapshot takes cnt_nxt so the snap cycle's own increment is captured.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         for (int unsigned i = 0; i < NCNT; i++) begin
            cnt_q[i]    <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NCNT; i++) begin
            cnt_q[i] <= cnt_nxt[i];
            if (i_snap) shadow_q[i] <= cnt_nxt[i];
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int unsigned i = 0; i < NCNT; i++) begin
         if (i_rd_sel == 4'(i)) rd_mux = shadow_q[i];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) o_rd_data <= '0;
      else         o_rd_data <= rd_mux;
   end

   logic [31:0] mem [TRACE_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          fifo_full, fifo_empty, push_req, push_ok, pop_ok;

   assign fifo_full  = (count == (AW+1)'(TRACE_DEPTH));
   assign fifo_empty = (count == '0);
   assign push_req   = inc[3];
   assign pop_ok     = i_trace_pop & ~fifo_empty;
   // A full FIFO still accepts a push when a pop frees the head slot this cycle.
   assign push_ok    = push_req & (~fifo_full | pop_ok);

   always_ff @(posedge i_clk) begin
      if (push_ok) mem[wr_ptr] <= i_pc;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         o_trace_ovf <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_req && !push_ok) o_trace_ovf <= 1'b1;
      end
   end

   assign o_trace_vld = ~fifo_empty;
   assign o_trace_cnt = count;
   assign o_trace_pc  = fifo_empty ? '0 : mem[rd_ptr];

endmodule

// File: doc/pipelined_perf_monitor.md
Name: pipelined_perf_monitor

Overview:
- Synthesizable commit-stage performance and trace monitor for the pipelined RISC-V core with branch prediction.
- Sits beside MEM/WB and consumes the WB-stage debug strobes: instruction valid, control-transfer and mispredict, plus WB PC.
- Keeps saturating event counters with an atomic snapshot and a start/stop/freeze state machine.
- Records mispredicted-branch PCs in a FIFO that hardware or a bench can drain.

Parameters:
- CNT_W, 32, width of every counter and of o_rd_data.
- N_EXT, 2, number of extra generic event inputs, 0..8.
- TRACE_DEPTH, 8, mispredict-PC FIFO depth; power of 2, at least 2.
- MISS_LIMIT, 0, mispredict count that auto-freezes counting; 0 disables auto-freeze.

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  STOPPED→RUNNING
- i_stop  in  1  RUNNING/FROZEN→STOPPED
- i_clear  in  1  zero counters, shadows, FIFO, ovf; state→STOPPED
- i_snap  in  1  copy live counters into shadow registers
- i_insn_vld  in  1  WB instruction retires this cycle
- i_ctrl  in  1  retiring instruction is branch/jump
- i_mispred  in  1  retiring control instruction was mispredicted
- i_pc  in  32  WB-stage PC
- i_ext_evt  in  N_EXT  generic events, one count per high cycle
- i_rd_sel  in  4  shadow counter select
- o_rd_data  out  CNT_W  selected shadow value, registered
- o_state  out  2  0 STOPPED, 1 RUNNING, 2 FROZEN
- o_trace_pc  out  32  FIFO head, first-word fall-through
- o_trace_vld  out  1  FIFO not empty
- i_trace_pop  in  1  pop head
- o_trace_cnt  out  $clog2(TRACE_DEPTH)+1  FIFO occupancy
- o_trace_ovf  out  1  sticky: a push was dropped because the FIFO was full

Behaviour:
- Reset (i_reset=1 at posedge):
  - All counters, shadows, FIFO pointers, o_rd_data, o_trace_ovf → 0; state → STOPPED.
  - Outputs are 0 the cycle after reset; o_trace_pc is 0 while empty.
  - Reset mid-operation discards everything; there is no partial drain.
- Priority per cycle: i_reset > i_clear > i_stop > i_start > auto-freeze.
- State machine:
  - STOPPED: i_start → RUNNING.
  - RUNNING: i_stop → STOPPED. If MISS_LIMIT≠0 and the mispred counter's next value equals MISS_LIMIT → FROZEN; that final increment is still applied.
  - FROZEN: i_stop → STOPPED. i_start is ignored.
- Counting happens only in RUNNING. Counter sources:
  - C0 cycles: every RUNNING cycle.
  - C1 retired: i_insn_vld.
  - C2 control: i_insn_vld & i_ctrl.
  - C3 mispred: i_insn_vld & i_ctrl & i_mispred.
  - C4+k: i_ext_evt[k].
- i_mispred and i_ctrl are ignored without i_insn_vld.
- Counters saturate at all-ones (2^CNT_W−1) and never wrap.
- Increments landing in the same cycle as i_clear are lost.
- Snapshot:
  - i_snap copies all live counters to shadows in one cycle, taking the value including that cycle's increment.
  - i_snap together with i_clear stores zeros.
- Read:
  - o_rd_data <= shadow[i_rd_sel] each cycle, 1-cycle latency.
  - Select 0..3+N_EXT is valid; any other select reads 0.
- Trace FIFO:
  - Push i_pc when RUNNING & i_insn_vld & i_ctrl & i_mispred.
  - Full and push without pop: push dropped, o_trace_ovf set.
  - Full with push and pop together: both take effect, occupancy unchanged, no ovf.
  - Empty with pop: pop ignored.
  - Empty with push and pop together: push accepted, pop ignored.
  - Pointers wrap modulo TRACE_DEPTH.
  - Popping continues in any state, including STOPPED and FROZEN.
- o_trace_ovf clears only on i_reset or i_clear.

Test Plan:
- Reset, then i_start, then 10 cycles with i_insn_vld=1 every cycle and i_ctrl=1 on 3 of them, then i_snap → sel0=11 (start cycle excluded, snap cycle included), sel1=10, sel2=3, sel3=0, o_state=1.
- CNT_W=4, RUNNING for 20 cycles, i_snap → sel0=15 (saturated, not 4); i_clear then i_snap → sel0=0, o_state=0.
- TRACE_DEPTH=4, 5 mispredicts at PCs 0x10,0x20,0x30,0x40,0x50 with no pops → o_trace_cnt=4, o_trace_ovf=1; pops return 0x10,0x20,0x30,0x40, then o_trace_vld=0.
- FIFO full (4), push 0x60 with simultaneous pop → head becomes 0x20, cnt stays 4, o_trace_ovf stays 0 if previously clear.
- MISS_LIMIT=2, two mispredicts → o_state=2 next cycle and sel3=2; further events and i_start leave counts unchanged; i_stop → o_state=0.
- i_reset asserted while RUNNING with FIFO cnt=3 → next cycle o_state=0, o_trace_vld=0, o_rd_data=0, all shadows read 0 after i_snap.
